// File: rtl/uart_sim_transmitter.sv
// 8N1 UART transmitter (LSB first, idle-high) fed from a valid/ready byte FIFO.
// Frames are sent back-to-back at CLOCK_FREQ/BAUD_RATE clocks per bit.
module uart_sim_transmitter #(
   parameter int CLOCK_FREQ = 100000000,
   parameter int BAUD_RATE  = 19200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [7:0]                    data_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   output logic                          txd_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   level_o
);

   localparam int DIV = CLOCK_FREQ / BAUD_RATE;
   localparam int CW  = $clog2(DIV);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LW  = AW + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

   if (DIV < 16) begin : g_div_check
      $error("uart_sim_transmitter: CLOCK_FREQ/BAUD_RATE must be >= 16");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
      $error("uart_sim_transmitter: FIFO_DEPTH must be a power of two >= 2");
   end

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [2:0]      bit_q;
   logic [7:0]      shift_q;
   logic            txd_q;
   logic [LW-1:0]   level_q, level_d;
   logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
   logic [7:0]      mem_q [FIFO_DEPTH];

   logic push, pop, baud_end;

   assign baud_end = (cnt_q == CNT_LAST);
   assign push     = valid_i && ready_o;
   // The FIFO is only drained at the instant the shift register is (re)loaded.
   assign pop      = (level_q != '0) &&
                     ((state_q == S_IDLE) || (state_q == S_STOP && baud_end));

   assign ready_o = (level_q != LVL_FULL);
   assign level_o = level_q;
   assign txd_o   = txd_q;
   assign busy_o  = (state_q != S_IDLE) || (level_q != '0);

   always_comb begin
      level_d = level_q;
      if (push && !pop) begin
         level_d = level_q + 1'b1;
      end else if (pop && !push) begin
         level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               txd_q <= 1'b1;
               if (pop) begin
                  shift_q <= mem_q[rd_ptr_q];
                  cnt_q   <= '0;
                  txd_q   <= 1'b0;
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (baud_end) begin
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  txd_q   <= shift_q[0];
                  state_q <= S_DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DATA: begin
               if (baud_end) begin
                  cnt_q <= '0;
                  if (bit_q == 3'd7) begin
                     txd_q   <= 1'b1;
                     state_q <= S_STOP;
                  end else begin
                     bit_q <= bit_q + 3'd1;
                     txd_q <= shift_q[bit_q + 3'd1];
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_STOP: begin
               if (baud_end) begin
                  cnt_q <= '0;
                  if (pop) begin
                     shift_q <= mem_q[rd_ptr_q];
                     txd_q   <= 1'b0;
                     state_q <= S_START;
                  end else begin
                     txd_q   <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               txd_q   <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_sim_transmitter.sv
// Bench for uart_sim_transmitter: a behavioural UART receiver and fill-count
// model form a scoreboard against which directed and random traffic is checked.
module tb_uart_sim_transmitter;

   localparam int CF    = 1600;
   localparam int BR    = 100;
   localparam int DIV   = CF / BR;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;
   localparam int FRAME = 10 * DIV;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic [7:0]    data_i = '0;
   logic          valid_i = 1'b0;
   logic          ready_o, txd_o, busy_o;
   logic [LW-1:0] level_o;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;

   // scoreboard / model state (written only by the monitor)
   logic [7:0]  exp_q[$];
   int unsigned starts[$];
   int          n_acc = 0;
   int          n_started = 0;
   bit          rx_active = 0;
   bit          expect_start = 0;

   uart_sim_transmitter #(
      .CLOCK_FREQ (CF),
      .BAUD_RATE  (BR),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .data_i  (data_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .txd_o   (txd_o),
      .busy_o  (busy_o),
      .level_o (level_o)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Monitor: mid-bit sampling receiver plus fill-count model n_acc - n_started.
   initial begin
      int unsigned start_cyc, off, bi, ph;
      logic [9:0]  bits;
      logic        cur;
      bit          glitch;
      int          lvl;
      start_cyc = 0;
      bits      = '0;
      cur       = 1'b1;
      glitch    = 0;
      forever begin
         @(negedge clk);
         if (rst_i) begin
            exp_q.delete();
            n_acc        = 0;
            n_started    = 0;
            rx_active    = 0;
            expect_start = 0;
         end else begin
            if (expect_start) chk("start_timing_txd", int'(txd_o), 0);
            expect_start = 0;
            if (!rx_active && txd_o == 1'b0) begin
               rx_active = 1;
               start_cyc = cyc;
               starts.push_back(cyc);
               n_started++;
               glitch = 0;
            end
            lvl = n_acc - n_started;
            chk("level", int'(level_o), lvl);
            chk("ready", int'(ready_o), int'(lvl != DEPTH));
            chk("busy", int'(busy_o), int'(rx_active || lvl != 0));
            if (rx_active) begin
               off = cyc - start_cyc;
               bi  = off / DIV;
               ph  = off % DIV;
               if (ph == 0) cur = txd_o;
               else if (txd_o !== cur) glitch = 1;
               if (ph == DIV / 2) bits[bi] = txd_o;
               if (off == FRAME - 1) begin
                  chk("frame_format", int'(bits[0] == 1'b0 && bits[9] == 1'b1 && !glitch), 1);
                  if (exp_q.size() == 0) begin
                     chk("frame_unexpected_byte", int'(bits[8:1]), -1);
                  end else begin
                     chk("frame_byte", int'(bits[8:1]), int'(exp_q.pop_front()));
                  end
                  rx_active = 0;
               end
            end
            if (!rx_active && lvl > 0) expect_start = 1;
            if (valid_i && lvl != DEPTH) begin
               exp_q.push_back(data_i);
               n_acc++;
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Source that holds valid_i until the byte is taken.
   task automatic push_hold(input logic [7:0] b);
      bit done;
      done    = 0;
      valid_i = 1'b1;
      data_i  = b;
      for (int k = 0; k < 4 * FRAME && !done; k++) begin
         @(negedge clk);
         done = ready_o;
         @(posedge clk);
         #1;
      end
      valid_i = 1'b0;
      if (!done) chk("push_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      bit idle;
      idle = 0;
      for (int k = 0; k < (DEPTH + 3) * FRAME && !idle; k++) begin
         if (!rx_active && n_acc == n_started) idle = 1;
         else step(1);
      end
      if (!idle) chk("drain_timeout", 0, 1);
      step(2);
   endtask

   initial begin
      string       s;
      int unsigned c, st, sidx;
      int          bad;

      step(3);
      rst_i = 1'b0;

      // idle line after reset
      step(2000);
      @(negedge clk);
      chk("idle_txd", int'(txd_o), 1);
      chk("idle_ready", int'(ready_o), 1);
      chk("idle_frames", starts.size(), 0);
      @(posedge clk);
      #1;

      // single byte: start bit begins one edge after acceptance
      c = cyc;
      push_hold(8'h4E);
      wait_idle();
      chk("single_frames", starts.size(), 1);
      if (starts.size() >= 1) chk("single_start_edge", int'(starts[0]), int'(c + 2));

      // back-to-back string
      s    = "NEORV32";
      sidx = starts.size();
      for (int i = 0; i < s.len(); i++) push_hold(s[i]);
      wait_idle();
      chk("string_frames", starts.size(), int'(sidx) + 7);
      if (starts.size() == sidx + 7) begin
         for (int i = 1; i < 7; i++)
            chk("string_gap", int'(starts[sidx + i] - starts[sidx + i - 1]), FRAME);
      end

      // full FIFO; 0x55 offered while full must be dropped
      push_hold(8'h10);
      step(3);
      push_hold(8'h11);
      push_hold(8'h22);
      push_hold(8'h33);
      push_hold(8'h44);
      @(negedge clk);
      chk("full_level", int'(level_o), 4);
      chk("full_ready", int'(ready_o), 0);
      @(posedge clk);
      #1;
      valid_i = 1'b1;
      data_i  = 8'h55;
      step(20);
      valid_i = 1'b0;
      @(negedge clk);
      chk("full_level_after_drop", int'(level_o), 4);
      @(posedge clk);
      #1;
      wait_idle();

      // push on the same edge as the STOP->START pop with two bytes queued
      push_hold(8'h61);
      step(2);
      push_hold(8'h62);
      push_hold(8'h63);
      st = starts[$];
      while (cyc < st + FRAME - 1) step(1);
      valid_i = 1'b1;
      data_i  = 8'h64;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      @(negedge clk);
      chk("simul_level", int'(level_o), 2);
      @(posedge clk);
      #1;
      wait_idle();

      // reset during data bit 3 of 0xA5 with three bytes queued
      push_hold(8'hA5);
      step(2);
      push_hold(8'h01);
      push_hold(8'h02);
      push_hold(8'h03);
      st = starts[$];
      while (cyc < st + 4 * DIV + 3) step(1);
      rst_i = 1'b1;
      step(1);
      rst_i = 1'b0;
      @(negedge clk);
      chk("rst_txd", int'(txd_o), 1);
      chk("rst_level", int'(level_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      bad = 0;
      for (int k = 0; k < 2 * FRAME; k++) begin
         @(negedge clk);
         if (txd_o !== 1'b1) bad++;
      end
      chk("rst_line_high_cycles_low", bad, 0);
      @(posedge clk);
      #1;

      // random traffic with a source that does not wait for ready
      for (int k = 0; k < 3000; k++) begin
         valid_i = ($urandom_range(0, 3) == 0);
         data_i  = 8'($urandom);
         step(1);
      end
      valid_i = 1'b0;
      wait_idle();
      chk("final_scoreboard_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_sim_transmitter.md
Name: uart_sim_transmitter

Overview:
- Serial UART transmitter (8N1, LSB first, idle-high line) that drives the processor's uart0_rxd_i from the bench or a stimulus block.
- It is the transmit-side counterpart to the bench UART receiver.
- Bytes are pushed through a valid/ready interface into an internal FIFO and serialised back-to-back at a fixed baud rate.
- Fully synthesizable, so it can also serve as a loopback stimulus source on hardware.

Parameters:
- CLOCK_FREQ, 100000000, core clock frequency in Hz.
- BAUD_RATE, 19200, serial bit rate. DIV = CLOCK_FREQ/BAUD_RATE, integer truncation. DIV >= 16 is required; elaboration fails otherwise.
- FIFO_DEPTH, 16, byte entries in the TX FIFO. Power of two, >= 2.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- data_i  in  8  byte to transmit.
- valid_i  in  1  data_i valid.
- ready_o  out  1  FIFO can accept a byte (not full).
- txd_o  out  1  serial line, connects to the DUT uart0_rxd_i.
- busy_o  out  1  frame in progress or FIFO non-empty.
- level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO fill count.

Behaviour:
- Reset (rst_i high at an edge): txd_o=1, ready_o=1, busy_o=0, level_o=0, FSM=IDLE, baud counter=0, bit index=0, FIFO pointers cleared.
  - Reset mid-frame truncates the frame immediately. The line is high from the next edge and all queued bytes are discarded.
- Push: a byte is written when valid_i && ready_o at an edge. ready_o = (level_o != FIFO_DEPTH), combinational from the registered count.
  - When full, valid_i is ignored and data is dropped by the source's choice. The FIFO is never overwritten.
- Pop: occurs only in the FSM cycle that loads the shift register.
  - Push and pop on the same edge: level_o unchanged, both succeed.
  - When full, a same-edge pop does not raise ready_o until the next cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd_o=1. If FIFO non-empty at an edge: pop into the shift register, counter=0, go to START.
  - START: txd_o=0 for exactly DIV cycles, then go to DATA with bit index 0.
  - DATA: txd_o = shift[bit index] for DIV cycles each, bits 0..7 (LSB first). After bit 7, go to STOP.
  - STOP: txd_o=1 for DIV cycles. At the end, if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- txd_o is a register; there is no combinational path from inputs to txd_o.
- Timing, for a byte accepted at edge E0 into an empty FIFO with the FSM in IDLE:
  - Pop at edge E1; txd_o low from E1.
  - Data bit k is driven from E1+(1+k)*DIV.
  - Stop bit from E1+9*DIV to E1+10*DIV.
  - Frame period is exactly 10*DIV cycles.
- Baud counter counts 0..DIV-1 and wraps at DIV-1, advancing the bit.
- busy_o = (FSM != IDLE) || (level_o != 0).
- FIFO addressing: pointers wrap modulo FIFO_DEPTH. Fill count is a separate counter of $clog2(FIFO_DEPTH)+1 bits.

Test Plan:
- Single byte (CLOCK_FREQ=100e6, BAUD=19200, DIV=5208): push 0x4E at E0 -> txd_o falls at E1, then holds 0,1,1,1,0,0,1,0 for 5208 cycles each, stop high at E1+46872, busy_o drops at E1+52080.
- Back-to-back string "NEORV32" pushed in 7 consecutive cycles -> 7 contiguous frames, 364560 cycles total, no idle high between stop and next start; looped into the bench UART receiver, it decodes N,E,O,R,V,3,2.
- Full FIFO (FIFO_DEPTH=4): while a frame is in progress push 0x11,0x22,0x33,0x44 -> level_o=4, ready_o=0; a fifth valid_i with 0x55 is ignored; the transmitted sequence contains no 0x55.
- Simultaneous push/pop: with level_o=2, push on the same edge the STOP→START pop occurs -> level_o stays 2, byte order preserved.
- Reset mid-frame: assert rst_i during data bit 3 of 0xA5 with 3 bytes queued -> txd_o=1 from next edge, level_o=0, busy_o=0; the line stays high for 2*10*DIV cycles afterward.
- Idle line: 100000 cycles after reset with valid_i=0 -> txd_o constantly 1, ready_o=1.
